// File: rtl/sdram_wfifo_ctrl.sv
// Write-side FWFT byte FIFO in front of sdram_write, with a one-shot burst trigger.
// Define SDRAM_WFIFO_ERRSTAT_EN to build the sticky ovf/udf flags and the drop counter.
module sdram_wfifo_ctrl #(
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter int THRESH = 4
) (
  input  logic          sclk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          wfifo_rd_en,
  output logic [7:0]    wfifo_rd_data,
  output logic          wr_trig,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf,
  output logic [7:0]    drop_cnt
);

  // state   | meaning
  // S_FILL  | buffering, waiting for level >= THRESH
  // S_TRIG  | one-cycle wr_trig pulse to sdram_write
  // S_DRAIN | burst in progress, back to S_FILL once drained and idle
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRIG  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        push, pop;
  state_e      state_q, state_d;

  // The extra wrap bit on each pointer separates full from empty.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign level = wp_q - rp_q;

  assign push = in_valid && !full;
  assign pop  = wfifo_rd_en && !empty;

  assign wp_d = push ? wp_q + (AW+1)'(1) : wp_q;
  assign rp_d = pop  ? rp_q + (AW+1)'(1) : rp_q;

  always_ff @(posedge sclk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wp_q[AW-1:0]] <= in_data;
    end
  end

  assign wfifo_rd_data = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (level >= THRESH_L) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty && !push) begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_comb begin
    wr_trig = 1'b0;
    if (state_q == S_TRIG) begin
      wr_trig = 1'b1;
    end
  end

`ifdef SDRAM_WFIFO_ERRSTAT_EN
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic [7:0] drop_q, drop_d;
  logic       drop_ev;

  assign drop_ev = in_valid && full;

  always_comb begin
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    drop_d = drop_q;
    if (drop_ev) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
    if (wfifo_rd_en && empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      drop_q <= drop_d;
    end
  end

  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign drop_cnt = drop_q;
`else
  assign ovf      = 1'b0;
  assign udf      = 1'b0;
  assign drop_cnt = 8'd0;
`endif

endmodule
